// File: rtl/iter_div_unit.sv
// iter_div_unit: multicycle RV32M divider for the EX stage (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per clock. Signed operations
// divide magnitudes and fix the sign when the result is registered.
// Divide-by-zero and signed overflow are resolved at acceptance and skip the
// iteration entirely.
//
// Ports:
//   clk         core clock, rising edge
//   reset_n     asynchronous active-low reset
//   start_i     request a division (taken in IDLE/DONE when kill_i is low)
//   fun3_i      100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes act as DIVU
//   dividend_i  rs1 value
//   divisor_i   rs2 value
//   kill_i      pipeline flush; abandons any operation, wins over start_i
//   busy_o      stall request: iterating, or a start is being taken this cycle
//   valid_o     one-cycle pulse marking result_o as fresh
//   result_o    quotient or remainder, held until the next completion
module iter_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [2:0]      fun3_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int              CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             is_rem_q, is_rem_d;

  // Operation decode and operand conditioning for the accepting cycle.
  logic            signed_op, rem_op, dvd_neg, dvs_neg;
  logic            div_zero, ovf, accept;
  logic [XLEN-1:0] dvd_abs, dvs_abs;

  assign signed_op = (fun3_i == 3'b100) || (fun3_i == 3'b110);
  assign rem_op    = (fun3_i == 3'b110) || (fun3_i == 3'b111);
  assign dvd_neg   = signed_op & dividend_i[XLEN-1];
  assign dvs_neg   = signed_op & divisor_i[XLEN-1];
  assign dvd_abs   = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_abs   = dvs_neg ? -divisor_i  : divisor_i;
  assign div_zero  = (divisor_i == '0);
  assign ovf       = signed_op && (dividend_i == INT_MIN) && (divisor_i == '1);
  assign accept    = (state_q != S_CALC) && start_i && !kill_i;

  // One restoring step. The partial remainder keeps its top bit in the shift
  // so unsigned divisors above 2^(XLEN-1) still divide correctly.
  logic [XLEN:0]   shifted, trial;
  logic            q_bit;
  logic [XLEN-1:0] rem_nx, quo_nx;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign q_bit   = ~trial[XLEN];
  assign rem_nx  = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_nx  = {quo_q[XLEN-2:0], q_bit};

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave a latch behind.
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    is_rem_d = is_rem_q;
    result_d = result_q;

    case (state_q)
      S_CALC: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d  = S_DONE;
            result_d = is_rem_q ? (r_neg_q ? -rem_nx : rem_nx)
                                : (q_neg_q ? -quo_nx : quo_nx);
          end
        end
      end
      default: begin
        // IDLE and DONE both accept; a DONE with no new start falls to IDLE.
        state_d = S_IDLE;
        if (accept) begin
          q_neg_d  = dvd_neg ^ dvs_neg;
          r_neg_d  = dvd_neg;
          is_rem_d = rem_op;
          dvs_d    = dvs_abs;
          quo_d    = dvd_abs;
          rem_d    = '0;
          cnt_d    = CNT_W'(XLEN-1);
          if (div_zero) begin
            state_d  = S_DONE;
            result_d = rem_op ? dividend_i : '1;
          end else if (ovf) begin
            state_d  = S_DONE;
            result_d = rem_op ? '0 : dividend_i;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: datapath registers are cleared too, so nothing stale survives a reset.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      is_rem_q <= is_rem_d;
      result_q <= result_d;
    end
  end

  // busy_o also rises in the accepting cycle so the front end stalls at once.
  assign busy_o   = (state_q == S_CALC) | (start_i & ~kill_i);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Testbench for iter_div_unit: directed vectors with literal expectations,
// control scenarios (kill, ignored start, back-to-back, async reset) and a
// randomized phase, all compared every cycle against a job-level model.
module tb_iter_div_unit;

  localparam int XLEN = 32;

  logic            clk        = 1'b0;
  logic            reset_n    = 1'b1;
  logic            start_i    = 1'b0;
  logic            kill_i     = 1'b0;
  logic [2:0]      fun3_i     = 3'b101;
  logic [XLEN-1:0] dividend_i = '0;
  logic [XLEN-1:0] divisor_i  = '0;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  int checks = 0;
  int errors = 0;

  iter_div_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (start_i),
    .fun3_i     (fun3_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .kill_i     (kill_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic bit is_signed_op(input logic [2:0] f);
    return (f == 3'b100) || (f == 3'b110);
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (is_signed_op(f) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    bit rm;
    rm = (f == 3'b110) || (f == 3'b111);
    if (b == 0) begin
      q = '1; r = a;
    end else if (is_signed_op(f) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0;
    end else if (is_signed_op(f)) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return rm ? r : q;
  endfunction

  // ---------------- job-level model ----------------
  // One outstanding job with the edge at which its result appears.
  int          edge_cnt   = 0;
  bit          job_active = 1'b0;
  int          job_done   = 0;
  logic [31:0] job_res    = '0;
  logic        exp_valid  = 1'b0;
  logic        exp_calc   = 1'b0;
  logic [31:0] exp_res    = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      job_active = 1'b0;
      exp_valid  = 1'b0;
      exp_calc   = 1'b0;
      exp_res    = '0;
    end else begin
      edge_cnt++;
      if (kill_i) begin
        if (job_active && job_done >= edge_cnt) job_active = 1'b0;
      end else if (start_i && !(job_active && job_done >= edge_cnt)) begin
        job_active = 1'b1;
        job_res    = ref_div(fun3_i, dividend_i, divisor_i);
        job_done   = edge_cnt + (is_special(fun3_i, dividend_i, divisor_i) ? 0 : XLEN);
      end
      exp_valid = job_active && (job_done == edge_cnt);
      if (exp_valid) exp_res = job_res;
      exp_calc  = job_active && (job_done > edge_cnt);
    end
  end

  always @(negedge clk) begin
    check("cyc_valid",  {31'b0, valid_o}, {31'b0, exp_valid});
    check("cyc_busy",   {31'b0, busy_o},  {31'b0, exp_calc | (start_i & ~kill_i)});
    check("cyc_result", result_o, exp_res);
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start_i    = 1'b1;
    fun3_i     = f;
    dividend_i = a;
    divisor_i  = b;
  endtask

  // Counts cycles (first negedge = 1) until valid_o, bounded.
  task automatic wait_valid(output int n, output int busy_n);
    bit found;
    found  = 1'b0;
    n      = 0;
    busy_n = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(negedge clk);
      if (busy_o)  busy_n++;
      if (valid_o) begin n = i; found = 1'b1; end
    end
    if (!found) check("valid_timeout", {31'b0, valid_o}, 32'd1);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid_o) pulses++;
    end
    check(name, pulses, 0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n, bn;
    check({"model_", name}, ref_div(v.f, v.a, v.b), v.r);
    drive(v.f, v.a, v.b);
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_valid(n, bn);
    check({name, "_result"},  result_o, v.r);
    check({name, "_latency"}, n, v.lat);
    check({name, "_busy_cycles"}, bn, v.lat - 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bn;

    vecs[0]  = '{3'b101, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{3'b111, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[5]  = '{3'b100, 32'hFFFF_FFF8,  32'hFFFF_FFFE,  32'd4,          33};
    vecs[6]  = '{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[7]  = '{3'b111, 32'd5,          32'd0,          32'd5,          1};
    vecs[8]  = '{3'b100, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1};
    vecs[9]  = '{3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
    vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[12] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[13] = '{3'b000, 32'd100,        32'd7,          32'd14,         33};
    vecs[14] = '{3'b111, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          33};

    // Reset state.
    #2 reset_n = 1'b0;
    #1;
    check("reset_valid",  {31'b0, valid_o}, 32'd0);
    check("reset_busy",   {31'b0, busy_o},  32'd0);
    check("reset_result", result_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with literal results and latencies.
    for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Kill during CALC: raised for cycle 10, unit idle in cycle 11, result kept.
    drive(3'b101, 32'd1000, 32'd3);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    check("kill_busy_after",  {31'b0, busy_o}, 32'd0);
    check("kill_result_kept", result_o, 32'd1);
    expect_quiet("kill_no_valid", 40);
    @(posedge clk); #1;

    // kill_i together with start_i: start dropped.
    drive(3'b101, 32'd9, 32'd3);
    kill_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    kill_i  = 1'b0;
    check("killstart_busy", {31'b0, busy_o}, 32'd0);
    expect_quiet("killstart_no_valid", 40);
    @(posedge clk); #1;

    // start_i during CALC is ignored; first operation completes on time.
    drive(3'b101, 32'd1000, 32'd10);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 drive(3'b101, 32'd7, 32'd7);
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_valid(n, bn);
    check("ignored_start_result",  result_o, 32'd100);
    check("ignored_start_latency", n, 28);
    expect_quiet("ignored_start_no_second", 40);
    @(posedge clk); #1;

    // Back-to-back: second start issued during the DONE cycle.
    drive(3'b101, 32'd100, 32'd7);
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_valid(n, bn);
    check("b2b_first_latency", n, 33);
    check("b2b_first_result",  result_o, 32'd14);
    #1 drive(3'b100, 32'hFFFF_FF9C, 32'd7);
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_valid(n, bn);
    check("b2b_second_latency", n, 33);
    check("b2b_second_result",  result_o, 32'hFFFF_FFF2);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of CALC.
    drive(3'b101, 32'd1000, 32'd3);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("areset_valid",  {31'b0, valid_o}, 32'd0);
    check("areset_busy",   {31'b0, busy_o},  32'd0);
    check("areset_result", result_o, 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    expect_quiet("areset_no_valid", 40);
    check("areset_result_after", result_o, 32'd0);
    @(posedge clk); #1;

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      int mode;
      mode    = $urandom_range(0, 9);
      start_i = ($urandom_range(0, 99) < 30);
      kill_i  = ($urandom_range(0, 99) < 2);
      fun3_i  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      dividend_i = $urandom;
      divisor_i  = $urandom;
      case (mode)
        0: divisor_i = '0;
        1: begin dividend_i = 32'h8000_0000; divisor_i = 32'hFFFF_FFFF; end
        2: divisor_i = $urandom_range(0, 1) ? 32'($urandom_range(1, 15)) : -32'($urandom_range(1, 15));
        3: dividend_i = 32'($urandom_range(0, 50));
        default: ;
      endcase
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    kill_i  = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
